// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter giving N_MASTERS native-bus masters access to one shared slave.
// Latency: one IDLE arbitration cycle, then the slave's own latency; back-to-back grants have one IDLE cycle between them.
// Backpressure: a master waits with valid held while another master owns the slave; requests are never dropped.
// Optional feature macro: ARB_TIMEOUT_EN adds a BUSY watchdog, the DRAIN state and the timeout_err port.
// Ports:
//   clk, rst     - single clock; asynchronous active-high reset
//   m_req        - N_MASTERS x {valid, address[31:0], wdata[31:0], wstrb[3:0]}, master 0 in the LSBs
//   m_resp       - N_MASTERS x {rdata[31:0], ready}, master 0 in the LSBs
//   s_req/s_resp - request to, and response from, the shared slave (same field layouts)
//   grant        - one-hot current owner; all-zero when idle
//   timeout_err  - one-cycle watchdog abort pulse (ARB_TIMEOUT_EN only)

`ifndef REQ_W
`define REQ_W 69
`endif
`ifndef RESP_W
`define RESP_W 33
`endif

module bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*`REQ_W-1:0]   m_req,
  output logic [N_MASTERS*`RESP_W-1:0]  m_resp,
  output logic [`REQ_W-1:0]             s_req,
  input  logic [`RESP_W-1:0]            s_resp,
  output logic [N_MASTERS-1:0]          grant
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int RQ   = `REQ_W;
  localparam int RS   = `RESP_W;
  localparam int IW   = $clog2(N_MASTERS);
  localparam int VBIT = RQ - 1;

  generate
    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1
`ifdef ARB_TIMEOUT_EN
    ,
    DRAIN = 2'd2
`endif
  } state_t;

  state_t         state;
  logic [IW-1:0]  last;     // most recently completed master
  logic [IW-1:0]  owner;    // binary index matching the one-hot grant

  logic [N_MASTERS-1:0] req_vld;
  logic [IW-1:0]        win_idx;
  logic                 win_found;
  logic [RQ-1:0]        owner_req;
  logic                 s_rdy;

  assign s_rdy     = s_resp[0];
  assign owner_req = m_req[int'(owner)*RQ +: RQ];

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      req_vld[i] = m_req[i*RQ + VBIT];
    end
  end

  // Walk the masters starting just after the last completed one; first valid wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      int cand;
      cand = int'(last) + 1 + k;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (!win_found && req_vld[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic [RQ-1:0] drain_req;  // aborted request, replayed to the slave until it answers
  logic          wd_fire;

  // The counter holds the number of completed BUSY cycles without ready, so the
  // abort lands in the TIMEOUT_CYCLES-th such cycle.
  assign wd_fire     = (state == BUSY) && !s_rdy && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = wd_fire;
`endif

  // Slave-side request mux.
  always_comb begin
    s_req = '0;
    if (state == BUSY) begin
      s_req = owner_req;
    end
`ifdef ARB_TIMEOUT_EN
    else if (state == DRAIN) begin
      s_req = drain_req;
    end
`endif
  end

  // Master-side response demux; only the owner ever sees a non-zero response.
  always_comb begin
    m_resp = '0;
    if (state == BUSY) begin
`ifdef ARB_TIMEOUT_EN
      if (wd_fire) begin
        m_resp[int'(owner)*RS +: RS] = {32'hDEADBEEF, 1'b1};
      end else begin
        m_resp[int'(owner)*RS +: RS] = s_resp;
      end
`else
      m_resp[int'(owner)*RS +: RS] = s_resp;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last  <= IW'(N_MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      drain_req <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
            owner <= win_idx;
            state <= BUSY;
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          // A master dropping valid early does not release the grant; only ready (or the watchdog) does.
          if (s_rdy) begin
            last  <= owner;
            grant <= '0;
            state <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_fire) begin
            last      <= owner;
            grant     <= '0;
            drain_req <= owner_req;
            state     <= DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        DRAIN: begin
          // The late slave response is swallowed here; the master was already answered.
          if (s_rdy) begin
            state <= IDLE;
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
`ifndef REQ_W
`define REQ_W 69
`endif
`ifndef RESP_W
`define RESP_W 33
`endif

module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int RQ = `REQ_W;
  localparam int RS = `RESP_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*RQ-1:0] m_req;
  logic [N*RS-1:0] m_resp;
  logic [RQ-1:0]   s_req;
  logic [RS-1:0]   s_resp;
  logic [N-1:0]    grant;
`ifdef ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Master and slave stimulus state
  logic        mv[N];
  logic [31:0] ma[N];
  logic [31:0] mw[N];
  logic [3:0]  ms[N];
  logic        s_rdy;
  logic [31:0] s_rdata;

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .grant  (grant)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [RQ-1:0] pack_req(input int i);
    return {mv[i], ma[i], mw[i], ms[i]};
  endfunction

  function automatic logic m_rdy(input int i);
    return m_resp[i*RS];
  endfunction

  function automatic logic [31:0] m_rd(input int i);
    return m_resp[i*RS+1 +: 32];
  endfunction

  function automatic int grant_idx(input logic [N-1:0] g);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) idx = i;
    return idx;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) m_req[i*RQ +: RQ] = pack_req(i);
    s_resp = {s_rdata, s_rdy};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; ma[i] = 32'h0; mw[i] = 32'h0; ms[i] = 4'h0;
    end
    s_rdy   = 1'b0;
    s_rdata = 32'h0;
    drive();
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("reset_grant", grant, '0);
    chk("reset_s_valid", s_req[RQ-1], 1'b0);
    chk("reset_m_resp", m_resp, '0);
`ifdef ARB_TIMEOUT_EN
    chk("reset_timeout_err", timeout_err, 1'b0);
`endif
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v0, v1, srdy;
    logic [31:0] rdata;
    logic [N-1:0] g;
    logic        r0, r1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl[9];

  // Reference-model state: who owns the slave, who finished last, slave delay remaining
  int  mdl_busy, mdl_owner, mdl_last, mdl_delay;
  bit  pend[N];
  bit  cool[N];
  int  order[$];
  int  drop[N];
  int  busy_age;
  int  exp_order[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Two masters requesting at once, slave answers in the third BUSY cycle
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        3'b001, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,        3'b001, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 3'b001, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        3'b010, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,        3'b010, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h12345678, 3'b010, 1'b0, 1'b1, 32'h0,        32'h12345678};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,        32'h0};

    do_reset();
    ma[0] = 32'h0000_1000; ma[1] = 32'h0000_2000;
    for (int i = 0; i < 9; i++) begin
      mv[0] = tbl[i].v0; mv[1] = tbl[i].v1;
      s_rdy = tbl[i].srdy; s_rdata = tbl[i].rdata;
      drive();
      #2;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_m0_ready", i), m_rdy(0), tbl[i].r0);
      chk($sformatf("tbl%0d_m1_ready", i), m_rdy(1), tbl[i].r1);
      chk($sformatf("tbl%0d_m0_rdata", i), m_rd(0), tbl[i].rd0);
      chk($sformatf("tbl%0d_m1_rdata", i), m_rd(1), tbl[i].rd1);
      chk($sformatf("tbl%0d_m2_resp", i), m_resp[2*RS +: RS], '0);
      next_cycle();
    end

    // Three masters requesting continuously: strict rotation from master 0
    do_reset();
    for (int i = 0; i < N; i++) drop[i] = 0;
    busy_age = 0;
    order.delete();
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      for (int i = 0; i < N; i++) mv[i] = (drop[i] == 0);
      s_rdy = (grant != '0) && (busy_age == 1);
      drive();
      #2;
      if (grant != '0 && busy_age == 0) order.push_back(grant_idx(grant));
      for (int i = 0; i < N; i++) drop[i] = int'(m_rdy(i));
      busy_age = (grant != '0) ? busy_age + 1 : 0;
      next_cycle();
    end
    exp_order = '{0, 1, 2, 0, 1, 2};
    chk("rotation_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rotation_%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
    end

    // Reset in the middle of a transaction: nothing is answered, master 0 wins afterwards
    do_reset();
    clear_inputs();
    mv[0] = 1'b1; drive(); #2; next_cycle();          // cycle 0
    s_rdy = 1'b1; drive(); #2;                          // cycle 1: m0 finishes
    chk("rst_seq_m0_ready", m_rdy(0), 1'b1);
    next_cycle();
    mv[0] = 1'b0; mv[1] = 1'b1; s_rdy = 1'b0; drive(); #2; next_cycle(); // cycle 2: IDLE
    drive(); #2;                                        // cycle 3: m1 BUSY cycle 1
    chk("rst_seq_m1_grant", grant, 3'b010);
    next_cycle();
    s_rdy = 1'b1; drive(); #1;                          // cycle 4: slave answers as reset hits
    rst = 1'b1;
    #1;
    chk("rst_mid_grant", grant, '0);
    chk("rst_mid_m_resp", m_resp, '0);
    chk("rst_mid_s_valid", s_req[RQ-1], 1'b0);
    next_cycle();
    #1;
    chk("rst_hold_m_resp", m_resp, '0);
    rst = 1'b0;
    s_rdy = 1'b0; mv[0] = 1'b1; mv[1] = 1'b1; drive(); #2;
    next_cycle();
    #2;
    chk("rst_after_grant", grant, 3'b001);
    next_cycle();

    // Write from master 0 is presented to the slave field for field
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h8000_0010; mw[0] = 32'h0BAD_F00D; ms[0] = 4'hF;
    drive(); #2;
    chk("wr_idle_s_valid", s_req[RQ-1], 1'b0);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      s_rdy = (c == 3);
      drive(); #2;
      chk($sformatf("wr_busy%0d_s_req", c), s_req, {1'b1, 32'h8000_0010, 32'h0BAD_F00D, 4'hF});
      next_cycle();
    end
    mv[0] = 1'b0; s_rdy = 1'b0; drive();

`ifdef ARB_TIMEOUT_EN
    // Silent slave: watchdog aborts m0 in its 8th BUSY cycle, m1 waits for the drain
    do_reset();
    ma[0] = 32'h0000_0040; mw[0] = 32'h1111_2222; ms[0] = 4'h3;
    for (int c = 0; c <= 22; c++) begin
      mv[0] = (c <= 8); mv[1] = 1'b1;
      s_rdy = (c == 20);
      drive(); #2;
      if (c >= 1 && c <= 7) begin
        chk($sformatf("to_c%0d_err", c), timeout_err, 1'b0);
        chk($sformatf("to_c%0d_grant", c), grant, 3'b001);
      end
      if (c == 8) begin
        chk("to_c8_m0_ready", m_rdy(0), 1'b1);
        chk("to_c8_m0_rdata", m_rd(0), 32'hDEADBEEF);
        chk("to_c8_err", timeout_err, 1'b1);
      end
      if (c >= 9 && c <= 20) begin
        chk($sformatf("to_c%0d_grant", c), grant, '0);
        chk($sformatf("to_c%0d_m_resp", c), m_resp, '0);
        chk($sformatf("to_c%0d_err", c), timeout_err, 1'b0);
      end
      if (c == 15) chk("to_drain_s_req", s_req, {1'b1, 32'h0000_0040, 32'h1111_2222, 4'h3});
      if (c == 21) chk("to_c21_grant", grant, '0);
      if (c == 22) chk("to_c22_grant", grant, 3'b010);
      next_cycle();
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    mdl_busy = 0; mdl_owner = 0; mdl_last = N - 1; mdl_delay = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; cool[i] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !cool[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom_range(0, 15));
        end
        cool[i] = 0;
        mv[i] = pend[i];
      end
      s_rdata = $urandom;
      if (mdl_busy) begin
        s_rdy = (mdl_delay == 0);
        if (mdl_delay > 0) mdl_delay--;
      end else begin
        s_rdy = 1'($urandom_range(0, 1));
      end
      drive();
      #2;
      chk("rnd_grant", grant, mdl_busy ? (N'(1) << mdl_owner) : N'(0));
      chk("rnd_s_valid", s_req[RQ-1], mdl_busy ? 1'b1 : 1'b0);
      if (mdl_busy) chk("rnd_s_req", s_req, pack_req(mdl_owner));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("rnd_m%0d_resp", i), m_resp[i*RS +: RS],
            (mdl_busy && i == mdl_owner) ? {s_rdata, s_rdy} : {RS{1'b0}});
      end
      if (mdl_busy) begin
        if (s_rdy) begin
          mdl_last = mdl_owner; mdl_busy = 0;
          pend[mdl_owner] = 0; cool[mdl_owner] = 1;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!mdl_busy && pend[(mdl_last + k) % N]) begin
            mdl_busy = 1; mdl_owner = (mdl_last + k) % N;
            mdl_delay = $urandom_range(0, 3);
          end
        end
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
